// File: rtl/spi_peripheral.sv
// SPI mode-0 responder oversampled in the clk domain: pin edges act 3 clk edges after they occur.
// One-byte transmit holding register; tx_load is ignored while it is full (tx_ready=0).
`timescale 1ns/1ps
module spi_peripheral #(
   parameter logic [7:0] DEFAULT_TX = 8'hFF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       SPI_SCLK,
   input  logic       SPI_CS,
   input  logic       SPI_MOSI,
   output logic       SPI_MISO,
   input  logic [7:0] tx_data,
   input  logic       tx_load,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   logic [2:0] sclk_sync_q, sclk_sync_d;
   logic [2:0] cs_sync_q, cs_sync_d;
   logic [1:0] mosi_sync_q, mosi_sync_d;

   state_t     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic [7:0] rx_shift_q, rx_shift_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic [7:0] hold_q, hold_d;
   logic       hold_full_q, hold_full_d;
   logic       miso_q, miso_d;

   logic       sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;
   logic       take_hold;
   logic [7:0] next_byte;

   // Edges and MOSI all come from stage 2 so the data bit lines up with its edge.
   assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
   assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
   assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
   assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
   assign mosi_s    = mosi_sync_q[1];
   assign next_byte = hold_full_q ? hold_q : DEFAULT_TX;

   always_comb begin
      sclk_sync_d = {sclk_sync_q[1:0], SPI_SCLK};
      cs_sync_d   = {cs_sync_q[1:0], SPI_CS};
      mosi_sync_d = {mosi_sync_q[0], SPI_MOSI};

      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      tx_shift_d  = tx_shift_q;
      rx_shift_d  = rx_shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      miso_d      = miso_q;
      take_hold   = 1'b0;

      case (state_q)
         IDLE: begin
            miso_d = 1'b0;
            if (cs_fall) begin
               tx_shift_d = next_byte;
               take_hold  = 1'b1;
               miso_d     = next_byte[7];
               bit_cnt_d  = 3'd0;
               state_d    = ACTIVE;
            end
         end
         ACTIVE: begin
            if (cs_rise) begin
               state_d   = IDLE;
               miso_d    = 1'b0;
               bit_cnt_d = 3'd0;
            end else if (sclk_rise) begin
               rx_shift_d = {rx_shift_q[6:0], mosi_s};
               bit_cnt_d  = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  rx_data_d  = {rx_shift_q[6:0], mosi_s};
                  rx_valid_d = 1'b1;
               end
            end else if (sclk_fall) begin
               // Counter at 0 means a byte just finished: start the next one without a gap.
               if (bit_cnt_q == 3'd0) begin
                  tx_shift_d = next_byte;
                  take_hold  = 1'b1;
                  miso_d     = next_byte[7];
               end else begin
                  tx_shift_d = {tx_shift_q[6:0], 1'b0};
                  miso_d     = tx_shift_q[6];
               end
            end
         end
         default: state_d = IDLE;
      endcase

      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      if (take_hold) begin
         hold_full_d = 1'b0;
      end
      if (tx_load && !hold_full_q) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      // Synchronizers are left out of reset so a held-low CS cannot fake a fresh cs_fall.
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      if (!rst_n) begin
         state_q     <= IDLE;
         bit_cnt_q   <= 3'd0;
         tx_shift_q  <= 8'h00;
         rx_shift_q  <= 8'h00;
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         hold_q      <= 8'h00;
         hold_full_q <= 1'b0;
         miso_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         tx_shift_q  <= tx_shift_d;
         rx_shift_q  <= rx_shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         miso_q      <= miso_d;
      end
   end

   assign SPI_MISO = miso_q;
   assign tx_ready = ~hold_full_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign busy     = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: a controller model drives the SPI pins, received bytes are scoreboarded.
`timescale 1ns/1ps
module tb_spi_peripheral;

   localparam int HALF = 80;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       SPI_SCLK, SPI_CS, SPI_MOSI;
   logic       SPI_MISO;
   logic [7:0] tx_data;
   logic       tx_load;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] rx_exp[$];
   longint     last_rise = 0;
   longint     rxv_time = 0;

   spi_peripheral #(.DEFAULT_TX(8'hFF)) dut (
      .clk(clk), .rst_n(rst_n),
      .SPI_SCLK(SPI_SCLK), .SPI_CS(SPI_CS), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO),
      .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: every rx_valid cycle must match the oldest expected byte.
   always @(negedge clk) begin
      if (rx_valid === 1'b1) begin
         rxv_time = $time;
         if (rx_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rx_valid actual=%0h required=none", rx_data);
         end else begin
            check("rx_data", {24'h0, rx_data}, {24'h0, rx_exp.pop_front()});
         end
      end
   end

   task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] got);
      got = 8'h00;
      for (int i = 0; i < n; i++) begin
         SPI_MOSI = b[7-i];
         #HALF;
         SPI_SCLK  = 1'b1;
         last_rise = $time;
         got[7-i]  = SPI_MISO;
         #HALF;
         SPI_SCLK = 1'b0;
      end
   endtask

   task automatic frame_start(input string tag);
      SPI_CS = 1'b0;
      #20;
      check({tag, "_busy_early"}, {31'h0, busy}, 32'h0);
      #10;
      check({tag, "_busy_rise"}, {31'h0, busy}, 32'h1);
      #(HALF - 30);
   endtask

   task automatic frame_end();
      #HALF;
      SPI_CS = 1'b1;
      #HALF;
   endtask

   task automatic load_tx(input logic [7:0] d);
      tx_data = d;
      tx_load = 1'b1;
      #10;
      tx_load = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] got, got2;
      logic [7:0] rx_before;
      rst_n = 1'b0; SPI_SCLK = 1'b0; SPI_CS = 1'b1; SPI_MOSI = 1'b0;
      tx_data = 8'h00; tx_load = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_miso", {31'h0, SPI_MISO}, 32'h0);
      check("rst_rx_data", {24'h0, rx_data}, 32'h0);
      check("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
      check("rst_tx_ready", {31'h0, tx_ready}, 32'h1);
      check("rst_busy", {31'h0, busy}, 32'h0);
      rst_n = 1'b1;
      #HALF;

      // Single byte with a preloaded transmit byte
      load_tx(8'h3C);
      check("t1_tx_ready_full", {31'h0, tx_ready}, 32'h0);
      rx_exp.push_back(8'hA5);
      frame_start("t1");
      spi_bits(8'hA5, 8, got);
      check("t1_rx_valid_latency", 32'(rxv_time - last_rise), 32'd30);
      frame_end();
      check("t1_miso_byte", {24'h0, got}, 32'h3C);
      check("t1_tx_ready_after", {31'h0, tx_ready}, 32'h1);
      check("t1_busy_after", {31'h0, busy}, 32'h0);
      check("t1_rx_data_hold", {24'h0, rx_data}, 32'hA5);

      // Nothing loaded: default byte goes out
      rx_exp.push_back(8'h81);
      frame_start("t2");
      spi_bits(8'h81, 8, got);
      frame_end();
      check("t2_miso_default", {24'h0, got}, 32'hFF);

      // Two back-to-back bytes, reloading mid-frame
      load_tx(8'h12);
      rx_exp.push_back(8'h5A);
      rx_exp.push_back(8'hC3);
      frame_start("t3");
      check("t3_tx_ready_mid", {31'h0, tx_ready}, 32'h1);
      load_tx(8'h34);
      check("t3_tx_ready_reload", {31'h0, tx_ready}, 32'h0);
      spi_bits(8'h5A, 8, got);
      spi_bits(8'hC3, 8, got2);
      frame_end();
      check("t3_miso_byte0", {24'h0, got}, 32'h12);
      check("t3_miso_byte1", {24'h0, got2}, 32'h34);
      check("t3_tx_ready_after", {31'h0, tx_ready}, 32'h1);

      // Aborted frame after 5 rises; a byte loaded mid-frame must survive
      rx_before = rx_data;
      check("t4_rx_before", {24'h0, rx_before}, 32'hC3);
      frame_start("t4");
      load_tx(8'h6E);
      spi_bits(8'hE7, 5, got);
      frame_end();
      check("t4_busy_drop", {31'h0, busy}, 32'h0);
      check("t4_rx_unchanged", {24'h0, rx_data}, {24'h0, rx_before});
      check("t4_hold_retained", {31'h0, tx_ready}, 32'h0);
      rx_exp.push_back(8'h0F);
      frame_start("t4b");
      spi_bits(8'h0F, 8, got);
      frame_end();
      check("t4_next_miso", {24'h0, got}, 32'h6E);
      check("t4_next_rx", {24'h0, rx_data}, 32'h0F);

      // Reset in the middle of a frame
      frame_start("t5");
      spi_bits(8'hF0, 4, got);
      rst_n = 1'b0;
      #20;
      check("t5_rst_miso", {31'h0, SPI_MISO}, 32'h0);
      check("t5_rst_rx_data", {24'h0, rx_data}, 32'h0);
      check("t5_rst_rx_valid", {31'h0, rx_valid}, 32'h0);
      check("t5_rst_tx_ready", {31'h0, tx_ready}, 32'h1);
      check("t5_rst_busy", {31'h0, busy}, 32'h0);
      rst_n = 1'b1;
      spi_bits(8'h0F, 4, got);
      #HALF;
      check("t5_ignored_busy", {31'h0, busy}, 32'h0);
      check("t5_ignored_rx", {24'h0, rx_data}, 32'h0);
      check("t5_ignored_miso", {31'h0, SPI_MISO}, 32'h0);
      SPI_CS = 1'b1;
      #HALF;
      rx_exp.push_back(8'h99);
      frame_start("t5b");
      spi_bits(8'h99, 8, got);
      frame_end();
      check("t5_next_miso", {24'h0, got}, 32'hFF);
      check("t5_next_rx", {24'h0, rx_data}, 32'h99);

      for (int i = 0; i < 100 && rx_exp.size() != 0; i++) @(negedge clk);
      check("scoreboard_drained", rx_exp.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_peripheral.md
# spi_peripheral

- SPI mode-0 responder (CPOL=0, CPHA=0, MSB first, 8-bit frames, active-low chip select) that sits on the far end of the `spi_controller` bus.
- Runs entirely in the system clock domain: it oversamples SCLK, CS and MOSI, so no logic is clocked by SCLK.
- It returns each received byte to local logic and shifts out a byte supplied by local logic.
- Multi-byte transfers with CS held low are supported back-to-back.

## Interface
- `DEFAULT_TX`, 8'hFF: byte shifted out when no transmit byte is pending at a frame start.
- `clk` input 1: system clock, 100 MHz nominal; all logic is on its rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `SPI_SCLK` input 1: serial clock from the controller, asynchronous to `clk`.
- `SPI_CS` input 1: chip select, active low, asynchronous.
- `SPI_MOSI` input 1: serial data from the controller, asynchronous.
- `SPI_MISO` output 1: serial data to the controller; always driven, no tristate.
- `tx_data` input 8: byte to send in a later frame.
- `tx_load` input 1: write strobe for `tx_data`; accepted only when `tx_ready`=1, otherwise ignored.
- `tx_ready` output 1: high while the transmit holding register is empty.
- `rx_data` output 8: last complete received byte; holds its value until the next byte completes.
- `rx_valid` output 1: one-cycle pulse when `rx_data` updates.
- `busy` output 1: high while a frame is in progress (state ACTIVE).

## Operation
- **Input synchronization:** SCLK, CS and MOSI each pass through 2 flops, plus a third flop for edge detection.
- **Edge events:**
  - `sclk_rise`, `sclk_fall`: transitions of synchronized SCLK.
  - `cs_fall`, `cs_rise`: transitions of synchronized CS.
  - Edge events and the MOSI value used with them come from the same synchronizer stage.
- **States:** IDLE and ACTIVE; a 3-bit bit counter and an 8-bit shift register.
- **IDLE:**
  - `SPI_MISO`=0, `busy`=0.
  - On `cs_fall`: load the shift register from the holding register (which then empties and `tx_ready`=1), or from `DEFAULT_TX` if the holding register is empty.
  - Same transition: drive `SPI_MISO` = shift[7], bit counter = 0, go to ACTIVE.
- **ACTIVE, `sclk_rise`:**
  - Shift the synchronized MOSI into the receive register LSB-first-in, so the MSB lands first.
  - Increment the bit counter.
  - On the 8th rise (counter 7→0, wraps), write the assembled byte to `rx_data` and pulse `rx_valid`.
- **ACTIVE, `sclk_fall`:**
  - Shift the transmit register left and drive the next bit onto `SPI_MISO`.
  - If the counter is 0 (a byte just completed), reload the shift register from the holding register or `DEFAULT_TX` instead, and drive its MSB. This gives back-to-back bytes with no gap.
- **ACTIVE, `cs_rise`:**
  - Return to IDLE and set `SPI_MISO`=0.
  - A partial byte (counter ≠ 0) is discarded with no `rx_valid` pulse; the holding register is retained.
- **`tx_load` on the same cycle as a shift-register load:** the load takes the holding register's prior content (`DEFAULT_TX` if it was empty). The new `tx_data` is stored in the holding register for the next frame, and `tx_ready` goes low.
- **`cs_rise` and `sclk_rise` on the same cycle:** `cs_rise` wins and the edge is ignored.
- **SCLK edges while in IDLE:** ignored.

## Timing
- **Reset values:**
  - `SPI_MISO`=0, `rx_data`=8'h00, `rx_valid`=0, `tx_ready`=1, `busy`=0.
  - Holding register empty, state IDLE, bit counter 0.
  - Reset mid-frame forces these values immediately; later SCLK edges are ignored until a fresh `cs_fall`.
- **Detection latency:** an edge on a pin is acted on at the 3rd `clk` rising edge after the transition. Registered outputs change at that same edge.
- **`rx_valid`:**
  - High for exactly 1 cycle, 3 `clk` cycles after the 8th SCLK rise.
  - `rx_data` is valid in the same cycle as `rx_valid` and remains stable afterwards.
- **`SPI_MISO` after a frame start:** valid 3 `clk` cycles after CS falls.
- **`SPI_MISO` bit updates:** 3 `clk` cycles after each SCLK fall.
- **Operating constraints:**
  - SCLK high and low phases ≥ 6 `clk` periods each.
  - CS-fall to first SCLK rise ≥ 6 `clk` periods.
  - The 100 MHz / 500 kHz ratio satisfies both with wide margin.
- **`busy`:** rises 3 cycles after CS falls and drops 3 cycles after CS rises.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles → all outputs at their reset values; `tx_ready`=1.
- **Single byte:**
  - Stimulus: `tx_load` 8'h3C, then `spi_controller` sends 8'hA5 with `hold_cs`=0.
  - Required: `rx_data`=8'hA5 with one `rx_valid` pulse; controller `data_received`=8'h3C; `tx_ready`=1 after the frame.
- **Empty holding register:** controller sends 8'h81 with nothing loaded → the controller receives 8'hFF (`DEFAULT_TX`).
- **Two bytes, CS held low:**
  - Stimulus: `tx_load` 8'h12, then reload 8'h34 while `tx_ready` is high mid-frame; controller sends 8'h5A then 8'hC3.
  - Required: two `rx_valid` pulses (8'h5A, 8'hC3); controller receives 8'h12, 8'h34.
- **Aborted frame:**
  - Stimulus: CS rises after 5 SCLK rises.
  - Required: no `rx_valid`, `rx_data` unchanged, `busy` drops. The next full frame with 8'h0F yields `rx_data`=8'h0F.
- **Reset mid-frame:**
  - Stimulus: assert `rst_n`=0 after bit 4 of 8'hF0.
  - Required: outputs return to reset values and no `rx_valid`; the following frame with 8'h99 is received correctly.
